handshake_src4: RTL



---
 rtl/handshake_src4_if.sv | 12 +
 rtl/handshake_src4.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/handshake_src4_if.sv
// Four-phase bundled-data channel between the clocked token source and the
// asynchronous circuit under prsim: req/data flow out, ack flows back.
interface handshake_src4_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/handshake_src4.sv
// Clocked four-phase bundled-data token source. Presents data, raises req one
// cycle later, waits for ack (synchronised), drops req, waits for ack to fall,
// then advances data and the token count. A stalled phase latches a sticky
// timeout flag and freezes the channel so the bench can report the stall.
// TIMEOUT must be at least 4 so the fastest legal ack round trip fits.
module handshake_src4 #(
    parameter int               WIDTH      = 8,
    parameter int               NUM_TOKENS = 16,
    parameter int               TIMEOUT    = 64,
    parameter logic [WIDTH-1:0] DATA_INIT  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    handshake_src4_if.master     hs,
    output logic [15:0]          sent_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] REQ_HI = 3'd2;
    localparam logic [2:0] REQ_LO = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    // The timer only has to count up to TIMEOUT-1: the edge that would make
    // it TIMEOUT is the edge that moves the FSM to ERR instead.
    localparam int              TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]     TOKEN_LIM  = 16'(NUM_TOKENS);

    logic [2:0]       state, state_n;
    logic             req_q, req_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [15:0]      count_n, count_inc;
    logic [TW-1:0]    timer, timer_n;
    logic             err_n;
    logic             ack_meta, ack_s;
    logic             timer_expired;

    assign hs.req  = req_q;
    assign hs.data = data_q;

    assign count_inc     = (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'd1;
    assign timer_expired = (timer == TIMER_LAST);

    // Two-flop synchroniser: ack comes from an unclocked circuit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, giving two real stages instead of one collapsed flop.
            ack_meta <= hs.ack;
            ack_s    <= ack_meta;
        end
    end

    // Next-state and next-output decode for the token FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_n = state;
        req_n   = req_q;
        data_n  = data_q;
        count_n = sent_count;
        timer_n = timer;
        err_n   = timeout_err;
        case (state)
            IDLE: begin
                if (enable) state_n = SETUP;
            end
            SETUP: begin
                // data has been stable for this cycle; req rises on entry.
                state_n = REQ_HI;
                req_n   = 1'b1;
                timer_n = '0;
            end
            REQ_HI: begin
                // Timeout wins over an ack arriving on the same edge.
                if (timer_expired) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end else if (ack_s) begin
                    state_n = REQ_LO;
                    req_n   = 1'b0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            REQ_LO: begin
                if (timer_expired) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end else if (!ack_s) begin
                    count_n = count_inc;
                    data_n  = data_q + WIDTH'(1);
                    if (NUM_TOKENS != 0 && count_inc == TOKEN_LIM) state_n = DONE;
                    else if (enable)                               state_n = SETUP;
                    else                                           state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            ERR: begin
                // req stays at whatever level the stall froze it at.
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; busy/done are decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            data_q      <= DATA_INIT;
            sent_count  <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            req_q       <= req_n;
            data_q      <= data_n;
            sent_count  <= count_n;
            timer       <= timer_n;
            timeout_err <= err_n;
            busy        <= (state_n == SETUP) || (state_n == REQ_HI) || (state_n == REQ_LO);
            done        <= (state_n == DONE);
        end
    end
endmodule
